// File: rtl/tff_count_sequencer.sv
// Up/down counter sequencer for an external bank of WIDTH T flip-flops.
// Optional feedback checking of q_fb against the mirror when TFF_SEQ_CHECK_EN is defined.
module tff_count_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             oneshot_q, oneshot_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] target;
    logic             upd;

    always_comb begin
        terminal = dir ? max_val : '0;
        if (dir) begin
            step_next = (cnt_q >= max_val) ? '0 : cnt_q + CntOne;
        end else begin
            step_next = (cnt_q == '0) ? max_val : cnt_q - CntOne;
        end
    end

    always_comb begin
        state_d   = state_q;
        oneshot_d = oneshot_q;
        tc_d      = 1'b0;
        upd       = 1'b0;
        target    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    upd    = 1'b1;
                    target = (load_val > max_val) ? max_val : load_val;
                end else if (start) begin
                    oneshot_d = oneshot;
                    // A one-shot already sitting on its terminal has nothing to count.
                    state_d   = (oneshot && (cnt_q == terminal)) ? StDone : StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (tick) begin
                    upd    = 1'b1;
                    target = step_next;
                    tc_d   = (step_next == terminal);
                    if (oneshot_q && tc_d) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cnt_d  = target;
        done_d = (state_d == StDone);
        // Bank and mirror toggle on the same edge; hold T low while in reset.
        t_vec  = (upd && rst_n) ? (cnt_q ^ target) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            oneshot_q <= 1'b0;
            tc_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            oneshot_q <= oneshot_d;
            tc_q      <= tc_d;
            done_q    <= done_d;
        end
    end

`ifdef TFF_SEQ_CHECK_EN
    logic err_q, err_d;

    // An accepted load resynchronises the mirror, so that edge's comparison is discarded.
    always_comb begin
        err_d = err_q | (q_fb != cnt_q);
        if ((state_q == StIdle) && load) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
    assign err         = 1'b0;
`endif

    assign cnt  = cnt_q;
    assign busy = (state_q == StRun);
    assign tc   = tc_q;
    assign done = done_q;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Self-checking bench for tff_count_sequencer: directed scenarios plus randomized run
// against a behavioural model, with a modelled T-FF bank driving q_fb.
module tb_tff_count_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start, stop, tick, dir, oneshot, load;
    logic [3:0] load_val, max_val, q_fb;
    logic [3:0] t_vec, cnt;
    logic       busy, tc, done, err;

    logic [3:0] bank;
    logic [3:0] fb_fault;

    int checks = 0;
    int errors = 0;

    tff_count_sequencer #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .dir      (dir),
        .oneshot  (oneshot),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .q_fb     (q_fb),
        .t_vec    (t_vec),
        .cnt      (cnt),
        .busy     (busy),
        .tc       (tc),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External T flip-flop bank, reset from the same rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank <= 4'h0;
        else        bank <= bank ^ t_vec;
    end
    assign q_fb = bank ^ fb_fault;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; tick = 0; dir = 0; oneshot = 0; load = 0;
        load_val = 0; fb_fault = 0;
    endtask

    task automatic test_reset();
        checks++; if (cnt !== 4'h0) begin errors++; $display("FAIL reset_cnt: got %0h want 0", cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %0b want 0", tc); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
        checks++; if (t_vec !== 4'h0) begin errors++; $display("FAIL reset_tvec: got %0h want 0", t_vec); end
    endtask

    task automatic test_load();
        max_val = 4'd9; load = 1; load_val = 4'd7; #1;
        checks++; if (t_vec !== 4'b0111) begin errors++; $display("FAIL load7_tvec: got %b want 0111", t_vec); end
        clk_step(); load = 0; #1;
        checks++; if (cnt !== 4'd7) begin errors++; $display("FAIL load7_cnt: got %0d want 7", cnt); end
        checks++; if (t_vec !== 4'h0) begin errors++; $display("FAIL load7_tvec_after: got %b want 0000", t_vec); end
        load = 1; load_val = 4'd12; #1;
        checks++; if (t_vec !== 4'b1110) begin errors++; $display("FAIL load12_tvec: got %b want 1110", t_vec); end
        clk_step(); load = 0;
        checks++; if (cnt !== 4'd9) begin errors++; $display("FAIL load12_clamp: got %0d want 9", cnt); end
    endtask

    task automatic test_free_run();
        load = 1; load_val = 4'd8; clk_step(); load = 0;
        start = 1; oneshot = 0; dir = 1; tick = 1;
        clk_step(); start = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL free_busy: got %0b want 1", busy); end
        checks++; if (t_vec !== 4'b0001) begin errors++; $display("FAIL free_tvec8: got %b want 0001", t_vec); end
        clk_step();
        checks++; if (cnt !== 4'd9) begin errors++; $display("FAIL free_cnt9: got %0d want 9", cnt); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL free_tc9: got %0b want 1", tc); end
        checks++; if (t_vec !== 4'b1001) begin errors++; $display("FAIL free_tvec_wrap: got %b want 1001", t_vec); end
        clk_step();
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL free_cnt0: got %0d want 0", cnt); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL free_tc0: got %0b want 0", tc); end
        clk_step();
        checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL free_cnt1: got %0d want 1", cnt); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL free_tc1: got %0b want 0", tc); end
        stop = 1; clk_step(); stop = 0; tick = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL free_stop_busy: got %0b want 0", busy); end
        checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL free_stop_cnt: got %0d want 1", cnt); end
    endtask

    task automatic test_oneshot_down();
        int run_cycles = 0;
        load = 1; load_val = 4'd3; clk_step(); load = 0;
        start = 1; oneshot = 1; dir = 0; tick = 0;
        clk_step(); start = 0; oneshot = 0;
        for (int i = 0; i < 6; i++) begin
            tick = i[0];
            if (busy === 1'b1) run_cycles++;
            clk_step();
            checks++;
            if (cnt !== 4'(3 - (i + 1) / 2)) begin
                errors++; $display("FAIL os_cnt_%0d: got %0d want %0d", i, cnt, 3 - (i + 1) / 2);
            end
        end
        tick = 0;
        checks++; if (run_cycles != 6) begin errors++; $display("FAIL os_run_cycles: got %0d want 6", run_cycles); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL os_done: got %0b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL os_done_busy: got %0b want 0", busy); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL os_tc: got %0b want 1", tc); end
        // Inputs during DONE must be ignored.
        start = 1; load = 1; load_val = 4'd5;
        clk_step(); start = 0; load = 0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL os_done_clear: got %0b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL os_idle: got %0b want 0", busy); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL os_ignore_load: got %0d want 0", cnt); end
    endtask

    task automatic test_priority();
        start = 1; dir = 1; oneshot = 0; tick = 0;
        clk_step(); start = 0; stop = 1; tick = 1; #1;
        checks++; if (t_vec !== 4'h0) begin errors++; $display("FAIL prio_stop_tvec: got %b want 0000", t_vec); end
        clk_step(); stop = 0; tick = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_stop_busy: got %0b want 0", busy); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL prio_stop_cnt: got %0d want 0", cnt); end
        load = 1; load_val = 4'd5; start = 1;
        clk_step(); load = 0; start = 0;
        checks++; if (cnt !== 4'd5) begin errors++; $display("FAIL prio_load_cnt: got %0d want 5", cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_load_busy: got %0b want 0", busy); end
        clk_step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_load_stay: got %0b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        start = 1; dir = 1; tick = 0;
        clk_step(); start = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: got %0b want 1", busy); end
        tick = 1; #2;
        rst_n = 0; #1;
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        checks++; if (t_vec !== 4'h0) begin errors++; $display("FAIL rmid_tvec: got %b want 0000", t_vec); end
        tick = 0;
        clk_step(); rst_n = 1;
    endtask

    task automatic test_check();
`ifdef TFF_SEQ_CHECK_EN
        fb_fault = 4'b0001; clk_step(); fb_fault = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk_set: got %0b want 1", err); end
        clk_step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk_sticky: got %0b want 1", err); end
        load = 1; load_val = 4'd2; clk_step(); load = 0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_load_clear: got %0b want 0", err); end
        load = 1; load_val = 4'd4; fb_fault = 4'b1000; clk_step(); load = 0; fb_fault = 0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_load_ignore: got %0b want 0", err); end
`else
        fb_fault = 4'b0001; clk_step(); clk_step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_off_a: got %0b want 0", err); end
        fb_fault = 4'b1111; clk_step(); fb_fault = 0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_off_b: got %0b want 0", err); end
`endif
    endtask

    // Behavioural reference: state 0 = idle, 1 = run, 2 = done.
    int m_state, m_cnt, m_os;
    bit m_tc, m_done, m_err;

    task automatic test_random();
        int mx_tab[4] = '{0, 15, 9, 5};
        for (int seg = 0; seg < 4; seg++) begin
            idle_inputs();
            rst_n = 0;
            max_val = (seg < 2) ? 4'(mx_tab[seg]) : 4'($urandom_range(15));
            clk_step(); rst_n = 1;
            m_state = 0; m_cnt = 0; m_os = 0; m_tc = 0; m_done = 0; m_err = 0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                int mx, term, nxt, tgt, n_state;
                bit upd;
                start    = ($urandom_range(99) < 20);
                stop     = ($urandom_range(99) < 5);
                tick     = ($urandom_range(99) < 60);
                load     = ($urandom_range(99) < 10);
                dir      = 1'($urandom_range(1));
                oneshot  = 1'($urandom_range(1));
                load_val = 4'($urandom_range(15));
                fb_fault = ($urandom_range(99) < 3) ? 4'($urandom_range(15, 1)) : 4'h0;

                mx      = int'(max_val);
                term    = dir ? mx : 0;
                if (dir) nxt = (m_cnt >= mx) ? 0 : m_cnt + 1;
                else     nxt = (m_cnt == 0) ? mx : m_cnt - 1;
                upd     = 0;
                tgt     = m_cnt;
                n_state = m_state;
                m_tc    = 0;
                if (m_state == 0) begin
                    if (load) begin
                        upd = 1; tgt = (int'(load_val) > mx) ? mx : int'(load_val);
                    end else if (start) begin
                        m_os = oneshot;
                        n_state = (oneshot && m_cnt == term) ? 2 : 1;
                    end
                end else if (m_state == 1) begin
                    if (stop) n_state = 0;
                    else if (tick) begin
                        upd = 1; tgt = nxt; m_tc = (nxt == term);
                        if (m_os != 0 && m_tc) n_state = 2;
                    end
                end else begin
                    n_state = 0;
                end
`ifdef TFF_SEQ_CHECK_EN
                if (m_state == 0 && load) m_err = 0;
                else if (fb_fault != 0) m_err = 1;
`endif
                #1;
                checks++;
                if (t_vec !== (upd ? 4'(m_cnt ^ tgt) : 4'h0)) begin
                    errors++; $display("FAIL rnd_tvec seg%0d cyc%0d: got %b want %b", seg, cyc, t_vec,
                                       upd ? 4'(m_cnt ^ tgt) : 4'h0);
                end
                clk_step();
                m_cnt = tgt; m_state = n_state; m_done = (n_state == 2);
                checks++; if (cnt !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt seg%0d cyc%0d: got %0d want %0d", seg, cyc, cnt, m_cnt); end
                checks++; if (bank !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_bank seg%0d cyc%0d: got %0d want %0d", seg, cyc, bank, m_cnt); end
                checks++; if (busy !== (m_state == 1)) begin errors++; $display("FAIL rnd_busy seg%0d cyc%0d: got %0b want %0b", seg, cyc, busy, m_state == 1); end
                checks++; if (tc !== m_tc) begin errors++; $display("FAIL rnd_tc seg%0d cyc%0d: got %0b want %0b", seg, cyc, tc, m_tc); end
                checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done seg%0d cyc%0d: got %0b want %0b", seg, cyc, done, m_done); end
                checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err seg%0d cyc%0d: got %0b want %0b", seg, cyc, err, m_err); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        max_val = 0;
        idle_inputs();
        #12;
        test_reset();
        @(posedge clk); #1;
        rst_n = 1;
        test_load();
        test_free_run();
        test_oneshot_down();
        test_priority();
        test_reset_mid();
        test_check();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
